// File: rtl/seg_display_pkg.sv
// Shared constants for the seven-segment display driver: digit count,
// blank/off patterns and the active-low {g,f,e,d,c,b,a} glyphs for 0..F.
package seg_display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg_display_driver_decoder.sv
// hex_seg_decoder: combinational nibble to active-low seven-segment cathode pattern.
module hex_seg_decoder
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_BLANK;
        case (nibble)
            4'h0: segments = SEG_0;
            4'h1: segments = SEG_1;
            4'h2: segments = SEG_2;
            4'h3: segments = SEG_3;
            4'h4: segments = SEG_4;
            4'h5: segments = SEG_5;
            4'h6: segments = SEG_6;
            4'h7: segments = SEG_7;
            4'h8: segments = SEG_8;
            4'h9: segments = SEG_9;
            4'hA: segments = SEG_A;
            4'hB: segments = SEG_B;
            4'hC: segments = SEG_C;
            4'hD: segments = SEG_D;
            4'hE: segments = SEG_E;
            4'hF: segments = SEG_F;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_driver.sv
// Four-digit multiplexed hex display driver with frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_display_driver
    import seg_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        update_pending,
    output logic        frame_done
);

    localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [1:0]       LAST_DIGIT = 2'(NUM_DIGITS - 1);

    logic [PRE_W-1:0] prescaler_reg;
    logic [1:0]       digit_reg;
    logic [15:0]      shadow_reg;
    logic [15:0]      display_reg;
    logic             pending_reg;

    logic       tick;
    logic       frame_edge;
    logic [3:0] cur_nibble;
    logic [6:0] seg_next;
    logic       blank;
    logic [3:0] anode_next;
    logic [6:0] cathode_next;

    assign tick       = (prescaler_reg == PRE_LAST);
    assign frame_edge = tick && (digit_reg == LAST_DIGIT);

    always_comb begin
        cur_nibble = display_reg[3:0];
        case (digit_reg)
            2'd0: cur_nibble = display_reg[3:0];
            2'd1: cur_nibble = display_reg[7:4];
            2'd2: cur_nibble = display_reg[11:8];
            2'd3: cur_nibble = display_reg[15:12];
            default: cur_nibble = display_reg[3:0];
        endcase
    end

    hex_seg_decoder u_decoder (
        .nibble   (cur_nibble),
        .segments (seg_next)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every nibble above it are zero; digit 0 always lights.
    always_comb begin
        blank = 1'b0;
        case (digit_reg)
            2'd1: blank = (display_reg[15:4] == 12'h000);
            2'd2: blank = (display_reg[15:8] == 8'h00);
            2'd3: blank = (display_reg[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign anode_next   = blank ? ANODE_OFF : ~(4'b0001 << digit_reg);
    assign cathode_next = blank ? SEG_BLANK : seg_next;

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            prescaler_reg <= '0;
            digit_reg     <= 2'd0;
            shadow_reg    <= 16'h0000;
            display_reg   <= 16'h0000;
            pending_reg   <= 1'b0;
            anode         <= ANODE_OFF;
            cathode       <= SEG_BLANK;
            frame_done    <= 1'b0;
        end else begin
            prescaler_reg <= tick ? '0 : prescaler_reg + 1'b1;
            if (tick) begin
                digit_reg <= digit_reg + 2'd1;
            end

            // A strobe on the frame edge wins for pending; display still takes the old shadow.
            if (frame_edge && pending_reg) begin
                display_reg <= shadow_reg;
            end
            if (din_valid) begin
                shadow_reg  <= din;
                pending_reg <= 1'b1;
            end else if (frame_edge) begin
                pending_reg <= 1'b0;
            end

            frame_done <= frame_edge;
            anode      <= anode_next;
            cathode    <= cathode_next;
        end
    end

    assign update_pending = pending_reg;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver at REFRESH_DIV=4; follows SEG_LEADING_ZERO_BLANK_EN when defined.
module tb_seg_display_driver;

    logic        clkin;
    logic        reset;
    logic [15:0] din;
    logic        din_valid;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        update_pending;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    seg_display_driver #(.REFRESH_DIV(4)) dut (
        .clkin          (clkin),
        .reset          (reset),
        .din            (din),
        .din_valid      (din_valid),
        .anode          (anode),
        .cathode        (cathode),
        .update_pending (update_pending),
        .frame_done     (frame_done)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic is_blank(input logic [15:0] v, input int d);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (d == 0) return 1'b0;
        return ((v >> (4 * d)) == 16'h0000);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_anode(input logic [15:0] v, input int d);
        if (is_blank(v, d)) return 4'b1111;
        case (d)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [6:0] exp_cathode(input logic [15:0] v, input int d);
        if (is_blank(v, d)) return 7'b1111111;
        return exp_seg(v[4*d +: 4]);
    endfunction

    // Advances to the negedge just after the next frame edge; to=1 if none within the budget.
    task automatic wait_frame(output bit to);
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clkin);
            if (frame_done === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; din = 16'h0000; din_valid = 1'b0;
        repeat (3) @(negedge clkin);
        tests++;
        if (anode !== 4'b1111 || cathode !== 7'b1111111 || update_pending !== 1'b0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: anode=%b cathode=%b pending=%b frame_done=%b, expected 1111 1111111 0 0",
                     anode, cathode, update_pending, frame_done);
        end
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clkin);
            tests++;
            if (anode !== exp_anode(16'h0000, (k-1)/4) || cathode !== exp_cathode(16'h0000, (k-1)/4) ||
                frame_done !== (k == 16)) begin
                fails++;
                $display("FAIL reset_scan k=%0d: anode=%b cathode=%b frame_done=%b, expected %b %b %b", k,
                         anode, cathode, frame_done, exp_anode(16'h0000, (k-1)/4),
                         exp_cathode(16'h0000, (k-1)/4), (k == 16));
            end
        end
        $display("[TB] reset release scan done");
    endtask

    task automatic test_display(input logic [15:0] v);
        bit to;
        din = v; din_valid = 1'b1;
        @(negedge clkin);
        din_valid = 1'b0;
        tests++;
        if (update_pending !== 1'b1) begin
            fails++;
            $display("FAIL display_pending_rise %h: pending=%b, expected 1", v, update_pending);
        end
        wait_frame(to);
        tests++;
        if (to || update_pending !== 1'b0) begin
            fails++;
            $display("FAIL display_frame %h: timeout=%0d pending=%b, expected timeout=0 pending=0", v, to, update_pending);
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clkin);
            tests++;
            if (anode !== exp_anode(v, (k-1)/4) || cathode !== exp_cathode(v, (k-1)/4) || frame_done !== (k == 16)) begin
                fails++;
                $display("FAIL display %h k=%0d: anode=%b cathode=%b frame_done=%b, expected %b %b %b", v, k,
                         anode, cathode, frame_done, exp_anode(v, (k-1)/4), exp_cathode(v, (k-1)/4), (k == 16));
            end
        end
        $display("[TB] display %h checked", v);
    endtask

    task automatic test_back_to_back();
        bit to;
        din = 16'h0001; din_valid = 1'b1;
        @(negedge clkin);
        din = 16'h0002;
        @(negedge clkin);
        din_valid = 1'b0;
        wait_frame(to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL back_to_back_frame: timeout=1, expected 0");
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clkin);
            tests++;
            if (anode !== exp_anode(16'h0002, (k-1)/4) || cathode !== exp_cathode(16'h0002, (k-1)/4)) begin
                fails++;
                $display("FAIL back_to_back k=%0d: anode=%b cathode=%b, expected %b %b", k, anode, cathode,
                         exp_anode(16'h0002, (k-1)/4), exp_cathode(16'h0002, (k-1)/4));
            end
        end
        $display("[TB] back-to-back strobes: last value 0002 shown");
    endtask

    // Entered aligned on the negedge after a frame edge, so the next frame edge is 16 posedges away.
    task automatic test_boundary_collision();
        din = 16'h1234; din_valid = 1'b1;
        @(negedge clkin);
        din_valid = 1'b0;
        repeat (14) @(negedge clkin);
        din = 16'hBEEF; din_valid = 1'b1;
        @(negedge clkin);
        din_valid = 1'b0;
        tests++;
        if (frame_done !== 1'b1 || update_pending !== 1'b1) begin
            fails++;
            $display("FAIL collision_edge: frame_done=%b pending=%b, expected 1 1", frame_done, update_pending);
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clkin);
            tests++;
            if (anode !== exp_anode(16'h1234, (k-1)/4) || cathode !== exp_cathode(16'h1234, (k-1)/4) ||
                frame_done !== (k == 16)) begin
                fails++;
                $display("FAIL collision_old k=%0d: anode=%b cathode=%b frame_done=%b, expected %b %b %b", k,
                         anode, cathode, frame_done, exp_anode(16'h1234, (k-1)/4),
                         exp_cathode(16'h1234, (k-1)/4), (k == 16));
            end
        end
        tests++;
        if (update_pending !== 1'b0) begin
            fails++;
            $display("FAIL collision_pending_fall: pending=%b, expected 0", update_pending);
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clkin);
            tests++;
            if (anode !== exp_anode(16'hBEEF, (k-1)/4) || cathode !== exp_cathode(16'hBEEF, (k-1)/4)) begin
                fails++;
                $display("FAIL collision_new k=%0d: anode=%b cathode=%b, expected %b %b", k, anode, cathode,
                         exp_anode(16'hBEEF, (k-1)/4), exp_cathode(16'hBEEF, (k-1)/4));
            end
        end
        $display("[TB] boundary collision: 1234 then BEEF");
    endtask

    task automatic test_reset_midframe();
        din = 16'h5555; din_valid = 1'b1;
        @(negedge clkin);
        din_valid = 1'b0;
        repeat (5) @(negedge clkin);
        tests++;
        if (update_pending !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pending_before: pending=%b, expected 1", update_pending);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (anode !== 4'b1111 || cathode !== 7'b1111111 || update_pending !== 1'b0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL midreset_async: anode=%b cathode=%b pending=%b frame_done=%b, expected 1111 1111111 0 0",
                     anode, cathode, update_pending, frame_done);
        end
        @(negedge clkin);
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clkin);
            tests++;
            if (anode !== exp_anode(16'h0000, (k-1)/4) || cathode !== exp_cathode(16'h0000, (k-1)/4) ||
                update_pending !== 1'b0 || frame_done !== (k == 16)) begin
                fails++;
                $display("FAIL midreset_after k=%0d: anode=%b cathode=%b pending=%b frame_done=%b, expected %b %b 0 %b",
                         k, anode, cathode, update_pending, frame_done, exp_anode(16'h0000, (k-1)/4),
                         exp_cathode(16'h0000, (k-1)/4), (k == 16));
            end
        end
        $display("[TB] mid-frame reset discards pending value");
    endtask

    initial begin
        test_reset();
        test_display(16'h1A2F);
        test_display(16'h0030);
        test_display(16'h0000);
        test_back_to_back();
        test_boundary_collision();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
